// File: rtl/dff_mem_fifo.sv
// Flip-flop memory with run-time RAM / FIFO mode, registered read port
// behind a valid/ready handshake, occupancy and sticky error flags.
module dff_mem_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              udf
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_udf;
    logic              r_mode_q;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_block;
    logic              w_rd_slot;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_ram_wr;
    logic              w_ram_rd;
    logic              w_wr_en;
    logic              w_rd_fire;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;

    // A mode change is treated like clr so the new mode starts from a clean state.
    assign w_block   = clr || (mode != r_mode_q);
    assign w_rd_slot = !r_out_valid || out_ready;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_DEPTH);

    assign wr_ready  = !w_block && (!mode || !w_full);

    assign w_push    = mode && wr_valid && wr_ready;
    assign w_pop     = !w_block && mode && rd_req && !w_empty && w_rd_slot;
    assign w_ram_wr  = !w_block && !mode && wr_valid;
    assign w_ram_rd  = !w_block && !mode && rd_req && w_rd_slot;

    assign w_wr_en   = w_push || w_ram_wr;
    assign w_rd_fire = w_pop || w_ram_rd;
    assign w_wr_idx  = mode ? r_wptr : wr_addr;
    assign w_rd_idx  = mode ? r_rptr : rd_addr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_mode_q <= 1'b0;
        end else if (w_block) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_mode_q <= mode;
        end else if (mode) begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_valid && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_req && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Read-before-write falls out of sampling r_mem with non-blocking updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_block) begin
            r_out_valid <= 1'b0;
        end else if (w_rd_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[w_rd_idx];
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign ovf       = r_ovf;
    assign udf       = r_udf;

endmodule

// File: tb/tb_dff_mem_fifo.sv
// Directed vector bench for dff_mem_fifo: RAM table, FIFO sequences,
// clr and asynchronous reset corner cases.
module tb_dff_mem_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       clr;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       udf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       mode;
        logic       clr;
        logic       wv;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       rr;
        logic [3:0] ra;
        logic       ordy;
        logic       e_wrdy;
        logic       e_ov;
        logic       cod;
        logic [7:0] e_od;
        logic [4:0] e_cnt;
        logic       e_ovf;
        logic       e_udf;
    } vec_t;

    dff_mem_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .clr       (clr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .udf       (udf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic m, input logic c, input logic wv,
        input logic [3:0] wa, input logic [7:0] wd,
        input logic rr, input logic [3:0] ra, input logic ordy,
        input logic e_wrdy, input logic e_ov, input logic cod,
        input logic [7:0] e_od, input logic [4:0] e_cnt,
        input logic e_ovf, input logic e_udf);
        vec_t v;
        v.mode = m; v.clr = c; v.wv = wv; v.wa = wa; v.wd = wd;
        v.rr = rr; v.ra = ra; v.ordy = ordy;
        v.e_wrdy = e_wrdy; v.e_ov = e_ov; v.cod = cod; v.e_od = e_od;
        v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; wr_ready is sampled on the
    // falling edge, registered outputs 1 time unit after the next rising edge.
    task automatic run(input string tag, input vec_t v);
        mode      = v.mode;
        clr       = v.clr;
        wr_valid  = v.wv;
        wr_addr   = v.wa;
        wr_data   = v.wd;
        rd_req    = v.rr;
        rd_addr   = v.ra;
        out_ready = v.ordy;
        @(negedge clk);
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(v.e_wrdy));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
        if (v.cod) chk({tag, ".out_data"}, 32'(out_data), 32'(v.e_od));
        chk({tag, ".count"}, 32'(count), 32'(v.e_cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(v.e_cnt == 5'd0));
        chk({tag, ".full"}, 32'(full), 32'(v.e_cnt == 5'd16));
        chk({tag, ".ovf"}, 32'(ovf), 32'(v.e_ovf));
        chk({tag, ".udf"}, 32'(udf), 32'(v.e_udf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ram_tab [12];
        ram_tab[0]  = mk(0,0,1,4'd3, 8'hA5,0,4'd0, 1, 1,0,1,8'h00,0,0,0);
        ram_tab[1]  = mk(0,0,1,4'd12,8'h5A,0,4'd0, 1, 1,0,1,8'h00,0,0,0);
        ram_tab[2]  = mk(0,0,0,4'd0, 8'h00,1,4'd3, 1, 1,1,1,8'hA5,0,0,0);
        ram_tab[3]  = mk(0,0,1,4'd3, 8'hFF,1,4'd3, 1, 1,1,1,8'hA5,0,0,0);
        ram_tab[4]  = mk(0,0,0,4'd0, 8'h00,1,4'd3, 1, 1,1,1,8'hFF,0,0,0);
        ram_tab[5]  = mk(0,0,1,4'd3, 8'hA5,0,4'd0, 1, 1,0,1,8'hFF,0,0,0);
        ram_tab[6]  = mk(0,0,0,4'd0, 8'h00,1,4'd12,0, 1,1,1,8'h5A,0,0,0);
        ram_tab[7]  = mk(0,0,0,4'd0, 8'h00,1,4'd3, 0, 1,1,1,8'h5A,0,0,0);
        ram_tab[8]  = mk(0,0,0,4'd0, 8'h00,1,4'd3, 1, 1,1,1,8'hA5,0,0,0);
        ram_tab[9]  = mk(0,0,0,4'd0, 8'h00,0,4'd0, 1, 1,0,1,8'hA5,0,0,0);
        ram_tab[10] = mk(1,0,1,4'd0, 8'h77,1,4'd0, 1, 0,0,1,8'hA5,0,0,0);
        ram_tab[11] = mk(1,0,0,4'd0, 8'h00,0,4'd0, 1, 1,0,1,8'hA5,0,0,0);

        rst = 1'b1; mode = 0; clr = 0; wr_valid = 0; wr_addr = 0;
        wr_data = 0; rd_req = 0; rd_addr = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.udf", 32'(udf), 32'd0);
        chk("rst.wr_ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run($sformatf("ram%0d", i), ram_tab[i]);
        end

        for (int i = 0; i < 16; i++) begin
            run($sformatf("fill%0d", i),
                mk(1,0,1,0,8'(i),0,0,1, 1,0,0,0,5'(i+1),0,0));
        end
        run("push_full", mk(1,0,1,0,8'hEE,0,0,1, 0,0,0,0,16,1,0));
        for (int i = 0; i < 16; i++) begin
            run($sformatf("drain%0d", i),
                mk(1,0,0,0,0,1,0,1, (i != 0),1,1,8'(i),5'(15-i),1,0));
        end
        run("pop_empty", mk(1,0,0,0,0,1,0,1, 1,0,1,8'h0F,0,1,1));
        run("clr0", mk(1,1,0,0,0,0,0,1, 0,0,1,8'h0F,0,0,0));

        for (int i = 0; i < 10; i++) begin
            run($sformatf("wpush%0d", i),
                mk(1,0,1,0,8'(8'h10+i),0,0,1, 1,0,0,0,5'(i+1),0,0));
        end
        for (int i = 0; i < 10; i++) begin
            run($sformatf("wpop%0d", i),
                mk(1,0,0,0,0,1,0,1, 1,1,1,8'(8'h10+i),5'(9-i),0,0));
        end
        for (int i = 0; i < 16; i++) begin
            run($sformatf("wrap%0d", i),
                mk(1,0,1,0,8'(8'h20+i),0,0,1, 1,0,0,0,5'(i+1),0,0));
        end
        run("full_pp", mk(1,0,1,0,8'h99,1,0,1, 0,1,1,8'h20,15,1,0));
        for (int i = 1; i < 16; i++) begin
            run($sformatf("wdrain%0d", i),
                mk(1,0,0,0,0,1,0,1, 1,1,1,8'(8'h20+i),5'(15-i),1,0));
        end
        run("empty_pp", mk(1,0,1,0,8'h55,1,0,1, 1,0,1,8'h2F,1,1,1));
        run("pop55", mk(1,0,0,0,0,1,0,0, 1,1,1,8'h55,0,1,1));

        for (int i = 0; i < 5; i++) begin
            run($sformatf("cpush%0d", i),
                mk(1,0,1,0,8'(8'h60+i),0,0,0, 1,1,1,8'h55,5'(i+1),1,1));
        end
        run("clr_push", mk(1,1,1,0,8'h70,0,0,0, 0,0,1,8'h55,0,0,0));
        run("after_clr", mk(1,0,0,0,0,1,0,1, 1,0,1,8'h55,0,0,1));

        for (int i = 0; i < 3; i++) begin
            run($sformatf("rpush%0d", i),
                mk(1,0,1,0,8'(8'h80+i),0,0,0, 1,0,0,0,5'(i+1),0,1));
        end
        run("rpop", mk(1,0,0,0,0,1,0,0, 1,1,1,8'h80,2,0,1));

        wr_valid = 1'b1; wr_data = 8'h90; rd_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.out_data", 32'(out_data), 32'd0);
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.full", 32'(full), 32'd0);
        chk("arst.ovf", 32'(ovf), 32'd0);
        chk("arst.udf", 32'(udf), 32'd0);
        wr_valid = 1'b0; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst.wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst.count", 32'(count), 32'd0);
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
